// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one sequential binary-to-BCD converter among
// four channels. Each channel's result is latched in its own bcd_out lane.
module bcd_conv_scheduler #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [47:0] bin_in,
    output logic [3:0]  ack,
    output logic        conv_start,
    output logic [11:0] conv_bin,
    input  logic        conv_done,
    input  logic [15:0] conv_bcd,
    output logic [63:0] bcd_out,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_STORE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  rr_ptr;
    logic [1:0]  pick;
    logic [7:0]  tmo_cnt;
    logic        timed_out;

    assign timed_out = (tmo_cnt == 8'(TIMEOUT - 1));

    // Descending scan so the requester closest above rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[rr_ptr + 2'(i)]) pick = rr_ptr + 2'(i);
        end
    end

    // NOTE: asynchronous reset in the sensitivity list, and non-blocking
    // assignments so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (|req) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (conv_done)      state_nxt = S_STORE;
                else if (timed_out) state_nxt = S_IDLE;
            end
            S_STORE:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        conv_start = (state == S_LAUNCH);
        busy       = (state != S_IDLE);
        ack        = (state == S_STORE) ? (4'b0001 << grant_id) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            conv_bin    <= '0;
            bcd_out     <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant_id <= pick;
                        conv_bin <= bin_in[int'(pick) * 12 +: 12];
                    end
                end
                S_LAUNCH: tmo_cnt <= '0;
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    // Completion takes priority over a simultaneous timeout.
                    if (conv_done) begin
                        bcd_out[int'(grant_id) * 16 +: 16] <= conv_bcd;
                    end else if (timed_out) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= grant_id + 2'd1;
                    end
                end
                S_STORE: rr_ptr <= grant_id + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Randomized self-checking bench for bcd_conv_scheduler against a
// transaction-level round-robin model; the bench also plays the converter.
module tb_bcd_conv_scheduler;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [47:0] bin_in;
    logic [3:0]  ack;
    logic        conv_start;
    logic [11:0] conv_bin;
    logic        conv_done;
    logic [15:0] conv_bcd;
    logic [63:0] bcd_out;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_bcd [4];
    int          exp_ptr;
    logic        exp_terr;

    bcd_conv_scheduler #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .bin_in      (bin_in),
        .ack         (ack),
        .conv_start  (conv_start),
        .conv_bin    (conv_bin),
        .conv_done   (conv_done),
        .conv_bcd    (conv_bcd),
        .bcd_out     (bcd_out),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic int model_pick(input logic [3:0] pat);
        for (int i = 0; i < 4; i++) begin
            if (pat[(exp_ptr + i) % 4]) return (exp_ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [63:0] model_lanes();
        return {exp_bcd[3], exp_bcd[2], exp_bcd[1], exp_bcd[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_bcd[i] = '0;
        exp_ptr  = 0;
        exp_terr = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req       = '0;
        conv_done = 1'b0;
        conv_bcd  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},   64'(ack),         64'h0);
        check({tag, "_start"}, 64'(conv_start),  64'h0);
        check({tag, "_busy"},  64'(busy),        64'h0);
        check({tag, "_bin"},   64'(conv_bin),    64'h0);
        check({tag, "_bcd"},   bcd_out,          64'h0);
        check({tag, "_gid"},   64'(grant_id),    64'h0);
        check({tag, "_terr"},  64'(timeout_err), 64'h0);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (conv_start) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // One conversion: delay is WAIT-cycle index of conv_done (>TMO means timeout).
    task automatic do_txn(input logic [3:0] pat, input int delay, input bit use_raw, input bit hold);
        int          ch;
        int          last;
        bit          ok;
        bit          op_ok;
        bit          no_ack;
        bit          done;
        logic [11:0] exp_op;
        logic [15:0] resp;

        req    = pat;
        ch     = model_pick(pat);
        exp_op = bin_in[ch * 12 +: 12];
        wait_start(ok);
        check("start_seen", 64'(ok), 64'h1);
        if (!ok) return;
        check("grant_id", 64'(grant_id), 64'(ch));
        check("conv_bin", 64'(conv_bin), 64'(exp_op));

        resp = use_raw ? 16'($urandom) : to_bcd(int'(exp_op));
        if (!hold) begin
            req    = 4'($urandom);
            bin_in = {16'($urandom), 32'($urandom)};
        end
        done   = (delay <= TMO);
        last   = done ? delay : TMO + 1;
        op_ok  = 1'b1;
        no_ack = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (!hold && k == 1) req = '0;
            if (conv_bin !== exp_op) op_ok = 1'b0;
            if (ack !== 4'b0) no_ack = 1'b0;
            if (k == delay) begin
                conv_done = 1'b1;
                conv_bcd  = resp;
            end
        end
        @(negedge clk);
        conv_done = 1'b0;
        check("operand_hold", 64'(op_ok), 64'h1);
        check("no_early_ack", 64'(no_ack), 64'h1);

        if (done) begin
            exp_bcd[ch] = resp;
            check("ack", 64'(ack), 64'(4'b0001 << ch));
        end else begin
            exp_terr = 1'b1;
            check("timeout_no_ack", 64'(ack), 64'h0);
        end
        exp_ptr = (ch + 1) % 4;
        check("bcd_out", bcd_out, model_lanes());
        check("timeout_err", 64'(timeout_err), 64'(exp_terr));
        if (!hold) begin
            if (done) @(negedge clk);
            check("busy_idle", 64'(busy), 64'h0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bin_in = '0;
        do_reset();
        check_all_zero("reset");

        // Single conversion of the largest operand.
        bin_in[11:0] = 12'd4095;
        do_txn(4'b0001, 3, 1'b0, 1'b0);
        check("single_lane", 64'(bcd_out[15:0]), 64'h4095);

        // Fairness with all channels requesting continuously.
        do_reset();
        bin_in = {12'd1234, 12'd100, 12'd9, 12'd0};
        for (int n = 0; n < 5; n++) do_txn(4'b1111, $urandom_range(1, TMO), 1'b0, 1'b1);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("fair_lanes", bcd_out, 64'h1234_0100_0009_0000);
        check("fair_idle", 64'(busy), 64'h0);

        // Timeout on channel 2 with a late pulse in IDLE, then channel 3 next.
        bin_in = {16'($urandom), 32'($urandom)};
        do_txn(4'b0100, TMO + 1, 1'b0, 1'b0);
        check("tmo_flag", 64'(timeout_err), 64'h1);
        do_txn(4'b1100, 2, 1'b0, 1'b0);
        check("after_tmo_gid", 64'(grant_id), 64'h3);

        // Operand stability on channel 1.
        bin_in[23:12] = 12'd50;
        do_txn(4'b0010, 4, 1'b0, 1'b0);
        check("stable_lane", 64'(bcd_out[31:16]), 64'h0050);

        // conv_done exactly on the timeout cycle.
        do_reset();
        bin_in = {16'($urandom), 32'($urandom)};
        do_txn(4'($urandom_range(1, 15)), TMO, 1'b1, 1'b0);
        check("tie_terr", 64'(timeout_err), 64'h0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            bin_in = {16'($urandom), 32'($urandom)};
            do_txn(4'($urandom_range(1, 15)), $urandom_range(1, TMO + 2), 1'($urandom), 1'b0);
        end

        // Reset during WAIT, late conv_done after release.
        begin
            bit ok;
            bin_in = {16'($urandom), 32'($urandom)};
            req    = 4'b0001;
            wait_start(ok);
            check("midrst_start", 64'(ok), 64'h1);
            req = '0;
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b0;
            #1;
            model_reset();
            check_all_zero("midrst_async");
            @(negedge clk);
            reset_n   = 1'b1;
            conv_bcd  = 16'h9999;
            conv_done = 1'b1;
            @(negedge clk);
            conv_done = 1'b0;
            check_all_zero("midrst_late");
            @(negedge clk);
            check_all_zero("midrst_after");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_conv_scheduler.md
BCD_CONV_SCHEDULER -- requirements
Module: bcd_conv_scheduler

Interface
REQ-001 Parameter: TIMEOUT, default 64, WAIT-state cycles allowed before a conversion is abandoned (range 2..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 req  input  4  per-channel level request; bit i = channel i wants a conversion.
REQ-006 bin_in  input  48  channel i operand at [12i+11:12i], unsigned 0..4095.
REQ-007 ack  output  4  one-cycle pulse on bit i when channel i's result is written.
REQ-008 conv_start  output  1  one-cycle start pulse to the shared sequential binary-to-BCD converter.
REQ-009 conv_bin  output  12  operand to converter, held stable from LAUNCH until the next IDLE.
REQ-010 conv_done  input  1  converter completion pulse; conv_bcd valid in the same cycle.
REQ-011 conv_bcd  input  16  converter result, four BCD digits, thousands in [15:12].
REQ-012 bcd_out  output  64  latched result per channel, channel i at [16i+15:16i].
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant_id  output  2  index of channel currently or most recently granted.
REQ-015 timeout_err  output  1  sticky flag, set on any abandoned conversion.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT, STORE; all outputs registered or decoded from registered state only.
REQ-017 IDLE: if any req bit high, select the first requesting channel searching upward (mod 4) from rr_ptr, register grant_id and conv_bin = that channel's bin_in, go to LAUNCH; else stay.
REQ-018 LAUNCH: conv_start = 1 for exactly this one cycle; clear timeout counter; go to WAIT.
REQ-019 WAIT: conv_done = 1 SHALL capture conv_bcd into bcd_out[grant_id] on that edge and go to STORE.
REQ-020 WAIT: counter reaching TIMEOUT-1 without conv_done SHALL set timeout_err, leave bcd_out unchanged, give no ack, set rr_ptr = grant_id+1, and go to IDLE.
REQ-021 conv_done and timeout in the same cycle: conv_done wins (normal completion).
REQ-022 STORE: ack[grant_id] = 1 for this one cycle; rr_ptr = grant_id+1 (mod 4); go to IDLE.
REQ-023 conv_done in IDLE, LAUNCH, or STORE SHALL be ignored.
REQ-024 bin_in and req changes after grant SHALL NOT affect conv_bin or the current conversion.
REQ-025 A req held high after its ack SHALL be re-served only in round-robin order; no channel waits more than 3 other grants.
REQ-026 Minimum issue-to-ack latency: req seen in IDLE cycle t -> conv_start at t+1 -> conv_done at earliest t+2 -> ack at t+3; back in IDLE at t+4.
REQ-027 Values in conv_bcd SHALL be stored verbatim; no digit range checking.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, rr_ptr=0, grant_id=0, conv_bin=0, bcd_out=0, ack=0, conv_start=0, busy=0, timeout_err=0.
REQ-029 Reset asserted mid-conversion SHALL abandon it without ack or bcd_out update; a late conv_done after release is ignored per REQ-023.
REQ-030 timeout_err SHALL clear only on reset.

Verification
REQ-031 Single: reset, req=0001, bin_in[11:0]=4095, model returns 16'h4095 3 cycles after start -> one conv_start, ack=0001 pulse, bcd_out[15:0]=16'h4095, busy low afterwards.
REQ-032 Fairness: req=1111 held, channel values 0,9,100,1234 -> grants in order 0,1,2,3,0..., bcd_out = 16'h1234_0100_0009_0000.
REQ-033 Timeout: req=0100, converter never responds -> timeout_err set after TIMEOUT WAIT cycles, no ack, bcd_out unchanged, next grant goes to channel 3 if requesting.
REQ-034 Operand stability: change bin_in[23:12] from 50 to 60 one cycle after grant of channel 1 -> conv_bin stays 50 until IDLE.
REQ-035 Mid-op reset: assert reset_n low during WAIT, then pulse conv_done after release -> all outputs zero, no ack, state IDLE.
REQ-036 Tie: conv_done on the exact timeout cycle -> result stored, ack pulsed, timeout_err stays 0.
